// File: rtl/pc_btb_if.sv
// Fetch/resolve bundle between the pipeline and pc_btb (names are from pc_btb's point of view).
// master: pipeline side driving EX resolution; slave: pc_btb.
interface pc_btb_if #(
    parameter int XLEN = 32
);
    logic            i_halt;
    logic            i_branch;
    logic            i_jal;
    logic            i_jalr;
    logic            i_eq;
    logic            i_slt;
    logic [2:0]      i_opsel;
    logic [XLEN-1:0] i_immediate;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_ex_pc;
    logic            i_ex_pred_taken;
    logic [XLEN-1:0] i_ex_pred_tgt;
    logic [XLEN-1:0] o_imem_raddr;
    logic            o_pred_taken;
    logic [XLEN-1:0] o_pred_tgt;
    logic [XLEN-1:0] o_nxt_pc;
    logic            o_flush;

    modport master (
        output i_halt, i_branch, i_jal, i_jalr, i_eq, i_slt, i_opsel,
               i_immediate, i_rs1, i_ex_pc, i_ex_pred_taken, i_ex_pred_tgt,
        input  o_imem_raddr, o_pred_taken, o_pred_tgt, o_nxt_pc, o_flush
    );

    modport slave (
        input  i_halt, i_branch, i_jal, i_jalr, i_eq, i_slt, i_opsel,
               i_immediate, i_rs1, i_ex_pc, i_ex_pred_taken, i_ex_pred_tgt,
        output o_imem_raddr, o_pred_taken, o_pred_tgt, o_nxt_pc, o_flush
    );
endinterface

// File: rtl/pc_btb.sv
// Next-PC generator with direct-mapped BTB and 2-bit counters; PC_BTB_PERF_EN adds branch/mispredict counters.
// Latency: prediction combinational on curr_pc; mispredict redirect takes effect at the next edge.
// Backpressure: none; i_halt freezes PC, BTB and counters.
module pc_btb #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int              BTB_DEPTH  = 16,
    parameter logic [1:0]      CTR_INIT   = 2'b01
) (
    input  logic        i_clk,
    input  logic        i_rst,
    pc_btb_if.slave     bus
`ifdef PC_BTB_PERF_EN
    ,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
`endif
);
    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [XLEN-1:0]                  curr_pc_q, curr_pc_d;
    logic [BTB_DEPTH-1:0]             valid_q, valid_d;
    logic [BTB_DEPTH-1:0][1:0]        ctr_q, ctr_d;
    logic [BTB_DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [BTB_DEPTH-1:0][XLEN-1:0]   tgt_q, tgt_d;

    logic [IDX-1:0]   f_idx, ex_idx;
    logic [TAG_W-1:0] f_tag, ex_tag;
    logic             f_hit, ex_hit;
    logic             br_taken, ctl, taken, mispred;
    logic [XLEN-1:0]  jalr_sum, target;

    assign f_idx = curr_pc_q[IDX+1:2];
    assign f_tag = curr_pc_q[XLEN-1:IDX+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign bus.o_imem_raddr = curr_pc_q;
    assign bus.o_pred_taken = f_hit & ctr_q[f_idx][1];
    assign bus.o_pred_tgt   = bus.o_pred_taken ? tgt_q[f_idx] : '0;

    always_comb begin
        br_taken = 1'b0;
        case (bus.i_opsel)
            3'b000:         br_taken = bus.i_eq;
            3'b001:         br_taken = ~bus.i_eq;
            3'b100, 3'b110: br_taken = bus.i_slt;
            3'b101, 3'b111: br_taken = ~bus.i_slt;
            default:        br_taken = 1'b0;
        endcase
        br_taken = br_taken & bus.i_branch;
    end

    assign ctl      = bus.i_branch | bus.i_jal | bus.i_jalr;
    assign taken    = br_taken | bus.i_jal | bus.i_jalr;
    assign jalr_sum = bus.i_rs1 + bus.i_immediate;
    assign target   = bus.i_jalr ? (jalr_sum & ~XLEN'(1)) : (bus.i_ex_pc + bus.i_immediate);
    assign mispred  = ctl & ((taken != bus.i_ex_pred_taken) |
                             (taken & (target != bus.i_ex_pred_tgt)));
    assign bus.o_flush = mispred & ~bus.i_halt;

    always_comb begin
        if (bus.i_halt)
            curr_pc_d = curr_pc_q;
        else if (mispred)
            curr_pc_d = taken ? target : (bus.i_ex_pc + XLEN'(4));
        else if (bus.o_pred_taken)
            curr_pc_d = bus.o_pred_tgt;
        else
            curr_pc_d = curr_pc_q + XLEN'(4);
    end
    assign bus.o_nxt_pc = curr_pc_d;

    assign ex_idx = bus.i_ex_pc[IDX+1:2];
    assign ex_tag = bus.i_ex_pc[XLEN-1:IDX+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Writes land at the edge, so a same-cycle fetch of this index sees the old entry.
    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (ctl && !bus.i_halt) begin
            if (bus.i_jal || bus.i_jalr) begin
                valid_d[ex_idx] = 1'b1;
                tag_d[ex_idx]   = ex_tag;
                tgt_d[ex_idx]   = target;
                ctr_d[ex_idx]   = 2'b11;
            end else if (ex_hit) begin
                if (taken) begin
                    tgt_d[ex_idx] = target;
                    if (ctr_q[ex_idx] != 2'b11)
                        ctr_d[ex_idx] = ctr_q[ex_idx] + 2'b01;
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_d[ex_idx] = ctr_q[ex_idx] - 2'b01;
                end
            end else if (taken) begin
                valid_d[ex_idx] = 1'b1;
                tag_d[ex_idx]   = ex_tag;
                tgt_d[ex_idx]   = target;
                ctr_d[ex_idx]   = 2'b10;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            curr_pc_q <= RESET_ADDR;
            valid_q   <= '0;
            ctr_q     <= {BTB_DEPTH{CTR_INIT}};
            tag_q     <= '0;
            tgt_q     <= '0;
        end else begin
            curr_pc_q <= curr_pc_d;
            valid_q   <= valid_d;
            ctr_q     <= ctr_d;
            tag_q     <= tag_d;
            tgt_q     <= tgt_d;
        end
    end

`ifdef PC_BTB_PERF_EN
    logic [31:0] br_cnt_q, br_cnt_d, mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        br_cnt_d      = br_cnt_q + {31'd0, (ctl & ~bus.i_halt)};
        mispred_cnt_d = mispred_cnt_q + {31'd0, bus.o_flush};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_br_cnt      = br_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
`endif
endmodule

// File: tb/tb_pc_btb.sv
// Directed bench for pc_btb: stimulus pushes expected fetch/redirect outputs, a negedge monitor checks them.
module tb_pc_btb;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_btb_if #(.XLEN(XLEN)) bif ();

`ifdef PC_BTB_PERF_EN
    logic [31:0] br_cnt, mis_cnt;
`endif

    pc_btb #(
        .XLEN(XLEN), .RESET_ADDR(32'h0), .BTB_DEPTH(16), .CTR_INIT(2'b01)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bif.slave)
`ifdef PC_BTB_PERF_EN
        ,
        .o_br_cnt(br_cnt),
        .o_mispred_cnt(mis_cnt)
`endif
    );

    typedef struct packed {
        logic [15:0] id;
        logic [31:0] raddr;
        logic        pt;
        logic [31:0] ptgt;
        logic        flush;
        logic [31:0] nxt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   stepn = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step%0d got=%h want=%h", nm, id, got, want);
        end
    endtask

    exp_t e_mon;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk("raddr",    int'(e_mon.id), bif.o_imem_raddr,        e_mon.raddr);
            chk("pred_tkn", int'(e_mon.id), {31'd0, bif.o_pred_taken}, {31'd0, e_mon.pt});
            chk("pred_tgt", int'(e_mon.id), bif.o_pred_tgt,          e_mon.ptgt);
            chk("flush",    int'(e_mon.id), {31'd0, bif.o_flush},    {31'd0, e_mon.flush});
            chk("nxt_pc",   int'(e_mon.id), bif.o_nxt_pc,            e_mon.nxt);
        end
    end

    task automatic clr_ex();
        bif.i_halt = 1'b0;          bif.i_branch = 1'b0;      bif.i_jal = 1'b0;
        bif.i_jalr = 1'b0;          bif.i_eq = 1'b0;          bif.i_slt = 1'b0;
        bif.i_opsel = 3'b000;       bif.i_immediate = '0;     bif.i_rs1 = '0;
        bif.i_ex_pc = '0;           bif.i_ex_pred_taken = 1'b0; bif.i_ex_pred_tgt = '0;
    endtask

    task automatic br(input logic [2:0] op, input logic eq, input logic slt, input logic [31:0] pc,
                      input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
        bif.i_branch = 1'b1; bif.i_opsel = op; bif.i_eq = eq; bif.i_slt = slt;
        bif.i_ex_pc = pc; bif.i_immediate = imm;
        bif.i_ex_pred_taken = pt; bif.i_ex_pred_tgt = ptgt;
    endtask

    task automatic jmp(input logic is_jalr, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1);
        bif.i_jal = ~is_jalr; bif.i_jalr = is_jalr;
        bif.i_ex_pc = pc; bif.i_immediate = imm; bif.i_rs1 = rs1;
        bif.i_ex_pred_taken = 1'b0; bif.i_ex_pred_tgt = '0;
    endtask

    // Not-taken beq predicted taken: forces a redirect to pc+4 without touching the BTB on a miss.
    task automatic redir(input logic [31:0] pc);
        br(3'b000, 1'b0, 1'b0, pc, 32'h0, 1'b1, 32'h0);
    endtask

    task automatic step(input logic [31:0] raddr, input logic pt, input logic [31:0] ptgt,
                        input logic fl, input logic [31:0] nxt);
        exp_t e;
        e.id = 16'(stepn); e.raddr = raddr; e.pt = pt; e.ptgt = ptgt; e.flush = fl; e.nxt = nxt;
        sb.push_back(e);
        stepn++;
        @(posedge clk);
        #1;
        clr_ex();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clr_ex();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // sequential fetch after reset
        step(32'h00, 0, 0, 0, 32'h04);
        step(32'h04, 0, 0, 0, 32'h08);
        step(32'h08, 0, 0, 0, 32'h0C);
        step(32'h0C, 0, 0, 0, 32'h10);
        // beq taken, predicted not-taken: allocate idx4 ctr=2
        br(3'b000, 1, 0, 32'h10, 32'h20, 0, 0);   step(32'h10, 0, 0, 1, 32'h30);
        redir(32'h0C);                            step(32'h30, 0, 0, 1, 32'h10);
        step(32'h10, 1, 32'h30, 0, 32'h30);
        // two more correct taken, then not-taken mispredict: ctr 2->3->3->2
        br(3'b000, 1, 0, 32'h10, 32'h20, 1, 32'h30); step(32'h30, 0, 0, 0, 32'h34);
        br(3'b000, 1, 0, 32'h10, 32'h20, 1, 32'h30); step(32'h34, 0, 0, 0, 32'h38);
        br(3'b000, 0, 0, 32'h10, 32'h20, 1, 32'h30); step(32'h38, 0, 0, 1, 32'h14);
        redir(32'h0C);                            step(32'h14, 0, 0, 1, 32'h10);
        step(32'h10, 1, 32'h30, 0, 32'h30);
        // jalr with bit0 cleared, then aliasing jal evicts it
        jmp(1, 32'h40, 32'h2, 32'h101);           step(32'h30, 0, 0, 1, 32'h102);
        redir(32'h3C);                            step(32'h102, 0, 0, 1, 32'h40);
        jmp(0, 32'h80, 32'h80, 32'h0);            step(32'h40, 1, 32'h102, 1, 32'h100);
        redir(32'hFC);                            step(32'h100, 0, 0, 1, 32'h100);
        redir(32'h3C);                            step(32'h100, 0, 0, 1, 32'h40);
        redir(32'h7C);                            step(32'h40, 0, 0, 1, 32'h80);
        step(32'h80, 1, 32'h100, 0, 32'h100);
        // halt during mispredicting jal: hold, no flush, no BTB write
        bif.i_halt = 1'b1; jmp(0, 32'h100, 32'h8, 32'h0); step(32'h100, 0, 0, 0, 32'h100);
        step(32'h100, 0, 0, 0, 32'h104);
        // condition decode, negative immediate, target mismatch, non-control slot
        br(3'b001, 0, 0, 32'h204, 32'h10, 1, 32'h214);        step(32'h104, 0, 0, 0, 32'h108);
        br(3'b100, 0, 1, 32'h300, 32'hFFFF_FFF8, 0, 0);       step(32'h108, 0, 0, 1, 32'h2F8);
        br(3'b111, 0, 1, 32'h20, 32'h40, 0, 0);               step(32'h2F8, 0, 0, 0, 32'h2FC);
        br(3'b010, 1, 1, 32'h400, 32'h40, 1, 32'h440);        step(32'h2FC, 0, 0, 1, 32'h404);
        bif.i_ex_pred_taken = 1'b1; bif.i_ex_pred_tgt = 32'h777; step(32'h404, 0, 0, 0, 32'h408);
        br(3'b101, 0, 0, 32'h500, 32'h40, 1, 32'h544);        step(32'h408, 0, 0, 1, 32'h540);
        // mid-run reset with a jal in EX: update must be dropped
        rst = 1'b1; jmp(0, 32'h540, 32'h4, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; clr_ex();
        step(32'h00, 0, 0, 0, 32'h04);
        step(32'h04, 0, 0, 0, 32'h08);
        step(32'h08, 0, 0, 0, 32'h0C);
        step(32'h0C, 0, 0, 0, 32'h10);
        redir(32'h53C);                           step(32'h10, 0, 0, 1, 32'h540);
        step(32'h540, 0, 0, 0, 32'h544);
        // four branches, two mispredicts
        br(3'b000, 1, 0, 32'h600, 32'h10, 1, 32'h610);        step(32'h544, 0, 0, 0, 32'h548);
        br(3'b001, 1, 0, 32'h604, 32'h10, 0, 0);              step(32'h548, 0, 0, 0, 32'h54C);
        br(3'b100, 0, 1, 32'h608, 32'h20, 0, 0);              step(32'h54C, 0, 0, 1, 32'h628);
        br(3'b111, 0, 1, 32'h60C, 32'h20, 1, 32'h62C);        step(32'h628, 0, 0, 1, 32'h610);
        step(32'h610, 0, 0, 0, 32'h614);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
`ifdef PC_BTB_PERF_EN
        chk("br_cnt",  0, br_cnt,  32'd5);
        chk("mis_cnt", 0, mis_cnt, 32'd3);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
